// File: rtl/ltpi_pkg.sv
// Shared types for the LTPI AVMM host arbiter.
//   state_t           : arbiter FSM states
//   cmd_t             : command latched from the granted host
//   ERR_RDATA_DEFAULT : read data returned to a host on an aborted read
//   sat_inc8          : saturating 8-bit increment for the error counter
package ltpi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RD_WAIT = 3'd2,
    ACK     = 3'd3,
    RESP    = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        rd;
  } cmd_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_DEAD;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ltpi_avmm_arbiter_if.sv
// Bus bundle for the LTPI AVMM arbiter.
//   h_* : two upstream hosts (index 0 = BMC side, 1 = local FPGA side)
//   m_* : single downstream command/response to the controller avmm_slv port
// Modports:
//   slave  : arbiter view (slave to the hosts, drives the downstream command)
//   master : environment view (hosts plus downstream controller)
interface ltpi_avmm_arbiter_if;
  logic [1:0][15:0] h_addr;
  logic [1:0]       h_read;
  logic [1:0]       h_write;
  logic [1:0][31:0] h_wdata;
  logic [1:0][3:0]  h_byteen;
  logic [31:0]      h_rdata;
  logic [1:0]       h_rdvalid;
  logic [1:0]       h_waitrq;

  logic [15:0]      m_addr;
  logic             m_read;
  logic             m_write;
  logic [31:0]      m_wdata;
  logic [3:0]       m_byteen;
  logic [31:0]      m_rdata;
  logic             m_rdvalid;
  logic             m_waitrq;

  modport slave (
    input  h_addr, h_read, h_write, h_wdata, h_byteen,
    output h_rdata, h_rdvalid, h_waitrq,
    output m_addr, m_read, m_write, m_wdata, m_byteen,
    input  m_rdata, m_rdvalid, m_waitrq
  );

  modport master (
    output h_addr, h_read, h_write, h_wdata, h_byteen,
    input  h_rdata, h_rdvalid, h_waitrq,
    input  m_addr, m_read, m_write, m_wdata, m_byteen,
    output m_rdata, m_rdvalid, m_waitrq
  );
endinterface

// File: rtl/ltpi_avmm_rr_arb.sv
// Two-way round-robin grant.
//   req      : per-host request
//   last_gnt : index of the host granted last
//   gnt      : one-hot grant (zero when nobody requests)
// On a tie the host that was not granted last wins.
module ltpi_avmm_rr_arb (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/ltpi_avmm_arbiter.sv
// Arbitrates two AVMM hosts onto the single LTPI controller avmm_slv port,
// one downstream transaction at a time, with a per-transaction timeout.
//   clk, reset           : 60 MHz LTPI clock, synchronous active-high reset
//   bus                  : host and downstream signals (slave modport)
//   data_channel_timeout : controller flags the current transaction invalid
//   err_pulse            : one-cycle pulse per aborted transaction
//   err_cnt              : aborted transaction count, saturates at 255
// A write completes with the host holding its request for 3 cycles:
// IDLE (grant) -> ISSUE (accepted) -> ACK (h_waitrq low).
module ltpi_avmm_arbiter
  import ltpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  ltpi_avmm_arbiter_if.slave  bus,
  input  logic                data_channel_timeout,
  output logic                err_pulse,
  output logic [7:0]          err_cnt
);
  state_t      state;
  cmd_t        cmd;
  logic        owner;
  logic        last_gnt;
  logic [15:0] tmo_cnt;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        gidx;
  logic        abort;

  assign req  = bus.h_read | bus.h_write;
  assign gidx = gnt[1];

  ltpi_avmm_rr_arb u_rr (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Only consulted in ISSUE/RD_WAIT, which is where a stray controller
  // timeout is meant to take effect.
  assign abort = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) || data_channel_timeout;

  assign bus.m_addr   = cmd.addr;
  assign bus.m_wdata  = cmd.wdata;
  assign bus.m_byteen = cmd.byteen;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd           <= '0;
      owner         <= 1'b0;
      last_gnt      <= 1'b1;
      tmo_cnt       <= '0;
      bus.m_read    <= 1'b0;
      bus.m_write   <= 1'b0;
      bus.h_waitrq  <= 2'b11;
      bus.h_rdvalid <= 2'b00;
      bus.h_rdata   <= '0;
      err_pulse     <= 1'b0;
      err_cnt       <= '0;
    end else begin
      err_pulse     <= 1'b0;
      bus.h_rdvalid <= 2'b00;
      bus.h_waitrq  <= 2'b11;
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner       <= gidx;
            last_gnt    <= gidx;
            cmd.addr    <= bus.h_addr[gidx];
            cmd.wdata   <= bus.h_wdata[gidx];
            cmd.byteen  <= bus.h_byteen[gidx];
            // read wins when a host raises both strobes
            cmd.rd      <= bus.h_read[gidx];
            bus.m_read  <= bus.h_read[gidx];
            bus.m_write <= ~bus.h_read[gidx];
            tmo_cnt     <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // acceptance is checked first so it beats a same-cycle abort
          if (!bus.m_waitrq) begin
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            if (cmd.rd) begin
              state <= RD_WAIT;
            end else begin
              bus.h_waitrq[owner] <= 1'b0;
              state               <= ACK;
            end
          end else if (abort) begin
            bus.m_read          <= 1'b0;
            bus.m_write         <= 1'b0;
            err_pulse           <= 1'b1;
            err_cnt             <= sat_inc8(err_cnt);
            bus.h_waitrq[owner] <= 1'b0;
            if (cmd.rd) bus.h_rdata <= ERR_RDATA;
            state               <= ACK;
          end
        end
        RD_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (bus.m_rdvalid) begin
            bus.h_rdata         <= bus.m_rdata;
            bus.h_waitrq[owner] <= 1'b0;
            state               <= ACK;
          end else if (abort) begin
            bus.h_rdata         <= ERR_RDATA;
            err_pulse           <= 1'b1;
            err_cnt             <= sat_inc8(err_cnt);
            bus.h_waitrq[owner] <= 1'b0;
            state               <= ACK;
          end
        end
        ACK: begin
          if (cmd.rd) begin
            bus.h_rdvalid[owner] <= 1'b1;
            state                <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_avmm_arbiter.sv
// Directed bench for ltpi_avmm_arbiter with TIMEOUT_CYCLES=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ltpi_avmm_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       data_channel_timeout;
  logic       err_pulse;
  logic [7:0] err_cnt;
  int         total = 0;
  int         bad   = 0;

  ltpi_avmm_arbiter_if bus ();

  ltpi_avmm_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .data_channel_timeout (data_channel_timeout),
    .err_pulse            (err_pulse),
    .err_cnt              (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset                = 1'b1;
    data_channel_timeout = 1'b0;
    bus.h_addr           = '0;
    bus.h_read           = 2'b00;
    bus.h_write          = 2'b00;
    bus.h_wdata          = '0;
    bus.h_byteen         = '0;
    bus.m_rdata          = '0;
    bus.m_rdvalid        = 1'b0;
    bus.m_waitrq         = 1'b0;
    step(); step();

    // reset values
    chk("rst_waitrq",  32'(bus.h_waitrq), 32'h3);
    chk("rst_rdvalid", 32'(bus.h_rdvalid), 32'h0);
    chk("rst_rdata",   bus.h_rdata, 32'h0);
    chk("rst_mrw",     32'({bus.m_read, bus.m_write}), 32'h0);
    chk("rst_maddr",   32'(bus.m_addr), 32'h0);
    chk("rst_err",     32'({err_pulse, err_cnt}), 32'h0);
    reset = 1'b0;
    step();

    // tie after reset: host 0 first, then host 1 (re-request tie alternates)
    bus.h_read    = 2'b11;
    bus.h_addr[0] = 16'h0100;
    bus.h_addr[1] = 16'h0200;
    step();
    chk("tie0_mread", 32'(bus.m_read), 32'h1);
    chk("tie0_maddr", 32'(bus.m_addr), 32'h0100);
    chk("tie0_wait",  32'(bus.h_waitrq), 32'h3);
    step();
    chk("tie0_mread_drop", 32'(bus.m_read), 32'h0);
    bus.m_rdvalid = 1'b1; bus.m_rdata = 32'h1111_0000;
    step();
    bus.m_rdvalid = 1'b0;
    chk("tie0_ack", 32'(bus.h_waitrq), 32'h2);
    step();
    chk("tie0_rdvalid", 32'(bus.h_rdvalid), 32'h1);
    chk("tie0_rdata",   bus.h_rdata, 32'h1111_0000);
    bus.h_addr[0] = 16'h0104;
    step();
    chk("tie0_rdvalid_off", 32'(bus.h_rdvalid), 32'h0);
    step();
    chk("tie1_maddr", 32'(bus.m_addr), 32'h0200);
    chk("tie1_mread", 32'(bus.m_read), 32'h1);
    step();
    bus.m_rdvalid = 1'b1; bus.m_rdata = 32'h2222_0000;
    step();
    bus.m_rdvalid = 1'b0;
    chk("tie1_ack", 32'(bus.h_waitrq), 32'h1);
    step();
    chk("tie1_rdvalid", 32'(bus.h_rdvalid), 32'h2);
    chk("tie1_rdata",   bus.h_rdata, 32'h2222_0000);
    bus.h_read[1] = 1'b0;
    step();
    step();
    chk("tie2_maddr", 32'(bus.m_addr), 32'h0104);
    step();
    bus.m_rdvalid = 1'b1; bus.m_rdata = 32'h3333_0000;
    step();
    bus.m_rdvalid = 1'b0;
    step();
    chk("tie2_rdvalid", 32'(bus.h_rdvalid), 32'h1);
    chk("tie2_rdata",   bus.h_rdata, 32'h3333_0000);
    bus.h_read = 2'b00;
    step();

    // host 1 read, stray m_rdvalid in ISSUE ignored, data 5 cycles after accept
    bus.h_read[1] = 1'b1; bus.h_addr[1] = 16'h0020;
    bus.m_waitrq = 1'b1; bus.m_rdvalid = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
    step();
    chk("rd1_maddr", 32'(bus.m_addr), 32'h0020);
    step();
    chk("rd1_mread_held", 32'(bus.m_read), 32'h1);
    bus.m_waitrq = 1'b0; bus.m_rdvalid = 1'b0;
    step();
    chk("rd1_mread_drop", 32'(bus.m_read), 32'h0);
    repeat (4) step();
    chk("rd1_wait_pending", 32'(bus.h_waitrq), 32'h3);
    bus.m_rdvalid = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
    step();
    bus.m_rdvalid = 1'b0;
    chk("rd1_ack", 32'(bus.h_waitrq), 32'h1);
    step();
    chk("rd1_rdvalid", 32'(bus.h_rdvalid), 32'h2);
    chk("rd1_rdata",   bus.h_rdata, 32'hCAFE_F00D);
    chk("rd1_errcnt",  32'(err_cnt), 32'h0);
    bus.h_read = 2'b00;
    step();

    // read timeout: 16 cycles in ISSUE+RD_WAIT, then ERR_RDATA
    bus.h_read[0] = 1'b1; bus.h_addr[0] = 16'h0030;
    repeat (16) step();
    chk("tmo_not_yet", 32'({err_pulse, bus.h_waitrq}), 32'h3);
    step();
    chk("tmo_pulse", 32'(err_pulse), 32'h1);
    chk("tmo_cnt",   32'(err_cnt), 32'h1);
    chk("tmo_ack",   32'(bus.h_waitrq), 32'h2);
    step();
    chk("tmo_rdvalid", 32'(bus.h_rdvalid), 32'h1);
    chk("tmo_rdata",   bus.h_rdata, 32'hDEAD_DEAD);
    chk("tmo_pulse_off", 32'(err_pulse), 32'h0);
    bus.h_read = 2'b00;
    step();

    // data_channel_timeout together with m_rdvalid: data wins
    bus.h_read[0] = 1'b1; bus.h_addr[0] = 16'h0040;
    step(); step();
    data_channel_timeout = 1'b1; bus.m_rdvalid = 1'b1; bus.m_rdata = 32'h5A5A_A5A5;
    step();
    data_channel_timeout = 1'b0; bus.m_rdvalid = 1'b0;
    chk("dct_race_err", 32'({err_pulse, err_cnt}), 32'h1);
    step();
    chk("dct_race_rdvalid", 32'(bus.h_rdvalid), 32'h1);
    chk("dct_race_rdata",   bus.h_rdata, 32'h5A5A_A5A5);
    bus.h_read = 2'b00;
    data_channel_timeout = 1'b1;
    step(); step(); step();
    chk("dct_idle_ignored", 32'({err_pulse, err_cnt}), 32'h1);
    data_channel_timeout = 1'b0;

    // reset while in RD_WAIT discards the read
    bus.h_read[1] = 1'b1; bus.h_addr[1] = 16'h0050;
    step(); step();
    reset = 1'b1; bus.m_rdvalid = 1'b1; bus.m_rdata = 32'h7777_7777;
    step();
    chk("rstmid_waitrq",  32'(bus.h_waitrq), 32'h3);
    chk("rstmid_rdvalid", 32'(bus.h_rdvalid), 32'h0);
    chk("rstmid_rdata",   bus.h_rdata, 32'h0);
    chk("rstmid_m",       32'({bus.m_read, bus.m_write, bus.m_addr}), 32'h0);
    chk("rstmid_err",     32'({err_pulse, err_cnt}), 32'h0);
    reset = 1'b0; bus.h_read = 2'b00; bus.m_rdvalid = 1'b0;
    step(); step();
    chk("rstmid_no_resp", 32'(bus.h_rdvalid), 32'h0);

    // host 0 write, 3-cycle latency
    bus.h_write[0] = 1'b1; bus.h_addr[0] = 16'h0010;
    bus.h_wdata[0] = 32'h0000_1234; bus.h_byteen[0] = 4'hF;
    step();
    chk("wr_mwrite", 32'({bus.m_write, bus.m_read}), 32'h2);
    chk("wr_maddr",  32'(bus.m_addr), 32'h0010);
    chk("wr_mwdata", bus.m_wdata, 32'h0000_1234);
    chk("wr_wait_hi", 32'(bus.h_waitrq), 32'h3);
    step();
    chk("wr_mwrite_off", 32'(bus.m_write), 32'h0);
    chk("wr_wait_lo",    32'(bus.h_waitrq), 32'h2);
    step();
    bus.h_write = 2'b00;
    chk("wr_wait_back", 32'(bus.h_waitrq), 32'h3);
    chk("wr_rdvalid",   32'(bus.h_rdvalid), 32'h0);
    step();

    // error counter saturation: every write aborts in its ISSUE cycle
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.m_waitrq = 1'b1; data_channel_timeout = 1'b1; bus.h_write[0] = 1'b1;
    repeat (761) step();
    chk("sat_254", 32'(err_cnt), 32'd254);
    repeat (3) step();
    chk("sat_255", 32'(err_cnt), 32'd255);
    repeat (36) step();
    chk("sat_hold", 32'({err_pulse, err_cnt}), 32'h1FF);
    bus.h_write = 2'b00; data_channel_timeout = 1'b0; bus.m_waitrq = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
